bus_cycle_gen: RTL and testbench

BUS_CYCLE_GEN -- requirements
Module: bus_cycle_gen

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_wait_timer.sv | 29 ++
 rtl/bus_cycle_gen.sv | 123 ++++++++++++
 tb/tb_bus_cycle_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the 8088-style bus cycle generator.
// Imported by the cycle FSM and its wait timer.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      T3,
      TW,
      T4
   } bus_state_t;

   localparam int ADDR_W_DEF   = 20;
   localparam int MAX_WAIT_DEF = 15;

   localparam logic IOM_IO  = 1'b1;
   localparam logic IOM_MEM = 1'b0;

   // Wait counter must hold 0..MAX_WAIT, never narrower than one bit.
   function automatic int cnt_w(input int mw);
      return (mw < 1) ? 1 : $clog2(mw + 1);
   endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts TW states of the current bus cycle.
// tc flags that the wait budget is used up.
module bus_wait_timer
   import bus_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = cnt_w(MAX_WAIT);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && !tc) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == W'(MAX_WAIT));

endmodule

// File: rtl/bus_cycle_gen.sv
// 8088-style bus cycle generator: T1/T2/T3/TW/T4 sequencing
// with READY wait states, timeout abort and back-to-back cycles.
module bus_cycle_gen
   import bus_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_io,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_wdata,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              rsp_err,
   output logic              ALE,
   output logic [ADDR_W-1:0] ADDRESS,
   output logic              IOM,
   output logic              RD,
   output logic              WR,
   output logic [7:0]        DATA_OUT,
   output logic              DATA_OE,
   input  logic [7:0]        DATA_IN,
   input  logic              READY
);

   bus_state_t        state;
   bus_state_t        nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q;
   logic              write_q;
   logic              iom_q;
   logic              hs;
   logic              tc;
   logic              timeout;
   logic              capture;
   logic              active;
   logic              wait_en;

   assign req_ready = !RESET && (state == IDLE || state == T4);
   assign hs        = req_valid && req_ready;
   assign ADDRESS   = addr_q;
   assign IOM       = iom_q;

   always_comb begin
      nxt     = state;
      timeout = 1'b0;
      capture = 1'b0;
      unique case (state)
         IDLE: if (hs) nxt = T1;
         T1:   nxt = T2;
         T2:   nxt = T3;
         T3, TW: begin
            if (READY) begin
               nxt     = T4;
               capture = !write_q;
            end else if (tc) begin
               nxt     = T4;
               timeout = 1'b1;
            end else begin
               nxt = TW;
            end
         end
         T4:   nxt = hs ? T1 : IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Strobes are registered, so decode them from the state being entered.
   assign active  = (nxt == T2) || (nxt == T3) || (nxt == TW);
   assign wait_en = (state == T3 || state == TW) && (nxt == TW);

   bus_wait_timer #(
      .MAX_WAIT(MAX_WAIT)
   ) u_wait (
      .clk  (CLK),
      .reset(RESET),
      .clr  (state == T1),
      .en   (wait_en),
      .tc   (tc)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         iom_q     <= IOM_MEM;
         ALE       <= 1'b0;
         RD        <= 1'b1;
         WR        <= 1'b1;
         DATA_OE   <= 1'b0;
         DATA_OUT  <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= nxt;
         if (hs) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            iom_q   <= req_io ? IOM_IO : IOM_MEM;
         end
         ALE       <= (nxt == T1);
         RD        <= !(active && !write_q);
         WR        <= !(active && write_q);
         DATA_OE   <= active && write_q;
         DATA_OUT  <= (active && write_q) ? wdata_q : 8'h00;
         rsp_valid <= (nxt == T4);
         rsp_err   <= timeout;
         if (capture) begin
            rsp_rdata <= DATA_IN;
         end
      end
   end

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Bench for bus_cycle_gen: a planned cycle timeline built from
// transaction-level rules, compared against the DUT every cycle.
module tb_bus_cycle_gen;

   localparam int AW = 20;
   localparam int MW = 15;
   localparam int N  = 4096;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic          req_io = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [7:0]    req_wdata = '0;
   logic          rsp_valid;
   logic [7:0]    rsp_rdata;
   logic          rsp_err;
   logic          ALE;
   logic [AW-1:0] ADDRESS;
   logic          IOM;
   logic          RD;
   logic          WR;
   logic [7:0]    DATA_OUT;
   logic          DATA_OE;
   logic [7:0]    DATA_IN = '0;
   logic          READY = 1'b0;

   always #5 CLK = ~CLK;

   bus_cycle_gen #(
      .ADDR_W(AW),
      .MAX_WAIT(MW)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_io(req_io),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ALE(ALE), .ADDRESS(ADDRESS), .IOM(IOM),
      .RD(RD), .WR(WR),
      .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
      .DATA_IN(DATA_IN), .READY(READY)
   );

   // stimulus per cycle
   bit            d_rst[N], d_vld[N], d_wr[N], d_io[N], d_rdy[N];
   logic [AW-1:0] d_addr[N];
   logic [7:0]    d_wd[N], d_din[N];
   // expectations per cycle
   bit            e_ale[N], e_rd[N], e_wr[N], e_oe[N], e_rv[N], e_err[N];
   bit            e_rreq[N], e_achk[N], e_iom[N], busy[N], rd_set[N];
   logic [AW-1:0] e_addr[N];
   logic [7:0]    e_dout[N], rd_val[N], e_rdata[N];
   // DUT samples
   bit            s_rv[N], s_err[N], s_rd[N], s_ale[N], s_oe[N];
   logic [7:0]    s_rdata[N], s_dout[N];

   int txn_t1[512];
   int txn_t4[512];
   int ntx = 0;
   int t4p = 2;
   int ap  = 1;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int t,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h want %0h", name, t, act, exp);
      end
   endtask

   // Plan one transaction: k = READY-low cycles starting at T3,
   // g = offset of req_valid relative to the bus becoming free.
   task automatic add_txn(input bit wr, input bit io,
                          input logic [AW-1:0] addr, input logic [7:0] wd,
                          input int k, input int g, input bit abort,
                          input int din_fix);
      int s, a, t1, t4, w;
      bit err;
      s = t4p + g - 2;
      if (s < ap + 1) s = ap + 1;
      a = (s > t4p) ? s : t4p;
      for (int t = ap + 1; t < t4p && t < s; t++) d_vld[t] = 1'($urandom);
      for (int t = s; t <= a; t++) begin
         d_vld[t] = 1'b1;
         d_wr[t] = wr; d_io[t] = io; d_addr[t] = addr; d_wd[t] = wd;
      end
      t1 = a + 1;
      e_ale[t1] = 1'b1;
      if (!abort) begin
         w   = (k < MW) ? k : MW;
         err = (k > MW);
         t4  = a + 4 + w;
         for (int i = 0; a + 3 + i < t4; i++) d_rdy[a+3+i] = (i >= k);
         if (din_fix >= 0) d_din[t4-1] = 8'(din_fix);
         e_rv[t4]  = 1'b1;
         e_err[t4] = err;
         if (!wr && !err) begin
            rd_set[t4] = 1'b1;
            rd_val[t4] = d_din[t4-1];
         end
      end else begin
         t4 = a + 6;
         for (int t = a + 3; t <= a + 5; t++) d_rdy[t] = 1'b0;
         d_rst[a+5]  = 1'b1;
         rd_set[t4]  = 1'b1;
         rd_val[t4]  = 8'h00;
         e_achk[t4]  = 1'b1;
         e_addr[t4]  = '0;
         e_iom[t4]   = 1'b0;
      end
      for (int t = a + 2; t < t4; t++) begin
         e_rd[t] = wr; e_wr[t] = !wr; e_oe[t] = wr; e_dout[t] = wd;
      end
      for (int t = t1; t < t4; t++) busy[t] = 1'b1;
      for (int t = t1; t <= t4; t++) begin
         if (!(abort && t == t4)) begin
            e_achk[t] = 1'b1; e_addr[t] = addr; e_iom[t] = io;
         end
      end
      txn_t1[ntx] = t1;
      txn_t4[ntx] = t4;
      ntx++;
      ap  = a;
      t4p = t4;
   endtask

   function automatic int cnt_low(input int lo, input int hi);
      int c = 0;
      for (int t = lo; t <= hi; t++) if (!s_rd[t]) c++;
      return c;
   endfunction

   initial begin
      int last, k, r, cur, oe_cnt, rv_cnt, t1;
      for (int t = 0; t < N; t++) begin
         d_wr[t] = 1'($urandom); d_io[t] = 1'($urandom);
         d_addr[t] = AW'($urandom); d_wd[t] = 8'($urandom);
         d_din[t] = 8'($urandom); d_rdy[t] = 1'($urandom);
         e_rd[t] = 1'b1; e_wr[t] = 1'b1;
      end
      d_rst[0] = 1'b1; d_rst[1] = 1'b1;
      e_achk[1] = 1'b1; e_achk[2] = 1'b1;
      e_addr[1] = '0; e_addr[2] = '0;

      add_txn(1'b0, 1'b0, 20'h0_1234, 8'h00, 0, 4, 1'b0, 8'hA5);
      add_txn(1'b1, 1'b0, 20'hF_FFFF, 8'h3C, 0, 4, 1'b0, -1);
      add_txn(1'b0, 1'b1, 20'h0_0777, 8'h00, 3, 3, 1'b0, -1);
      add_txn(1'b0, 1'b0, 20'hA_BCDE, 8'h00, 20, 2, 1'b0, -1);
      add_txn(1'b1, 1'b1, 20'h1_1111, 8'h5A, 0, 4, 1'b0, -1);
      add_txn(1'b0, 1'b0, 20'h2_2222, 8'h00, 0, 0, 1'b0, -1);
      add_txn(1'b0, 1'b0, 20'h3_3333, 8'h00, 30, 3, 1'b1, -1);
      add_txn(1'b0, 1'b1, 20'h4_4444, 8'h00, 0, 4, 1'b0, 8'h96);
      while (t4p < N - 80 && ntx < 400) begin
         r = $urandom_range(0, 9);
         if (r < 5) k = 0;
         else if (r < 8) k = $urandom_range(1, 5);
         else k = $urandom_range(13, 18);
         add_txn(1'($urandom), 1'($urandom), AW'($urandom), 8'($urandom),
                 k, $urandom_range(0, 5), ($urandom_range(0, 24) == 0), -1);
      end
      last = t4p + 5;
      cur = 0;
      for (int t = 0; t <= last; t++) begin
         e_rreq[t] = !d_rst[t] && !busy[t];
         if (rd_set[t]) cur = rd_val[t];
         e_rdata[t] = 8'(cur);
      end

      for (int t = 0; t <= last; t++) begin
         @(posedge CLK);
         #1;
         RESET = d_rst[t]; req_valid = d_vld[t]; req_write = d_wr[t];
         req_io = d_io[t]; req_addr = d_addr[t]; req_wdata = d_wd[t];
         DATA_IN = d_din[t]; READY = d_rdy[t];
         @(negedge CLK);
         s_rv[t] = rsp_valid; s_err[t] = rsp_err; s_rd[t] = RD;
         s_ale[t] = ALE; s_oe[t] = DATA_OE;
         s_rdata[t] = rsp_rdata; s_dout[t] = DATA_OUT;
         if (t >= 1) begin
            chk("req_ready", t, req_ready, e_rreq[t]);
            chk("ALE", t, ALE, e_ale[t]);
            chk("RD", t, RD, e_rd[t]);
            chk("WR", t, WR, e_wr[t]);
            chk("DATA_OE", t, DATA_OE, e_oe[t]);
            chk("rsp_valid", t, rsp_valid, e_rv[t]);
            chk("rsp_rdata", t, rsp_rdata, e_rdata[t]);
            if (e_rv[t]) chk("rsp_err", t, rsp_err, e_err[t]);
            if (e_oe[t]) chk("DATA_OUT", t, DATA_OUT, e_dout[t]);
            if (e_achk[t]) begin
               chk("ADDRESS", t, ADDRESS, e_addr[t]);
               chk("IOM", t, IOM, e_iom[t]);
            end
         end
      end

      t1 = txn_t1[0];
      chk("lit_rd_ale", t1, s_ale[t1], 1);
      chk("lit_rd_rv", t1 + 3, s_rv[t1+3], 1);
      chk("lit_rd_data", t1 + 3, s_rdata[t1+3], 8'hA5);
      chk("lit_rd_low", t1, cnt_low(t1, t1 + 4), 2);
      t1 = txn_t1[1];
      oe_cnt = 0;
      for (int t = t1; t <= t1 + 4; t++) if (s_oe[t]) oe_cnt++;
      chk("lit_wr_oe", t1, oe_cnt, 2);
      chk("lit_wr_dout", t1 + 1, s_dout[t1+1], 8'h3C);
      chk("lit_wr_rv", t1 + 3, s_rv[t1+3], 1);
      chk("lit_wr_err", t1 + 3, s_err[t1+3], 0);
      t1 = txn_t1[2];
      chk("lit_w3_rv", t1 + 6, s_rv[t1+6], 1);
      chk("lit_w3_low", t1, cnt_low(t1, t1 + 6), 5);
      t1 = txn_t1[3];
      chk("lit_to_rv", t1 + 18, s_rv[t1+18], 1);
      chk("lit_to_err", t1 + 18, s_err[t1+18], 1);
      chk("lit_to_low", t1, cnt_low(t1, t1 + 18), 17);
      t1 = txn_t1[4];
      chk("lit_b2b_rv", t1 + 3, s_rv[t1+3], 1);
      chk("lit_b2b_ale", t1 + 4, s_ale[t1+4], 1);
      t1 = txn_t1[6];
      chk("lit_rst_rd", t1 + 5, s_rd[t1+5], 1);
      rv_cnt = 0;
      for (int t = t1; t <= t1 + 8; t++) if (s_rv[t]) rv_cnt++;
      chk("lit_rst_norv", t1, rv_cnt, 0);
      t1 = txn_t1[7];
      chk("lit_after_rv", t1 + 3, s_rv[t1+3], 1);
      chk("lit_after_data", t1 + 3, s_rdata[t1+3], 8'h96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
